// File: rtl/div_config_arbiter.sv
// Round-robin arbiter that owns the load protocol of a shared frequency divider.
// Optional build macro DIV_SKIP_SAME_EN: a request equal to CUR_DIV is acknowledged without reloading.
//
// state   | meaning
// IDLE    | DIV_ENABLE follows RUN; arbitrate pending requests
// DISABLE | divider stopped so it clears its counter
// LOAD    | DIV_CONFIG pulse with the latched divisor
// SETTLE  | divider held stopped for SETTLE_CYCLES cycles
// RESUME  | ACK to the winner; divider restarted if RUN
module div_config_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       RUN,
    input  logic [NUM_REQ-1:0]         REQ,
    input  logic [NUM_REQ*WIDTH-1:0]   REQ_DIV,
    output logic [NUM_REQ-1:0]         ACK,
    output logic [NUM_REQ-1:0]         ACK_ERR,
    output logic                       DIV_ENABLE,
    output logic                       DIV_CONFIG,
    output logic [WIDTH-1:0]           DIV_DIN_n,
    output logic [WIDTH-1:0]           CUR_DIV,
    output logic                       BUSY
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DISABLE = 3'd1;
    localparam logic [2:0] ST_LOAD    = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_RESUME  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      idx_q, idx_d;
    logic [WIDTH-1:0]   val_q, val_d;
    logic [NUM_REQ-1:0] ack_d, err_d;
    logic               en_d, cfg_d, busy_d;
    logic [WIDTH-1:0]   din_d, cur_d;

    logic [WIDTH-1:0]   div_slot [NUM_REQ];
    logic               grant_found;
    logic [PW-1:0]      grant_idx;
    logic [PW-1:0]      ptr_after;
    logic [WIDTH-1:0]   grant_val;

    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            div_slot[i] = REQ_DIV[i*WIDTH +: WIDTH];
        end
    end

    // Walk downward so the set bit closest above the pointer is the last one written.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (REQ[rr_index(ptr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_index(ptr_q, k);
            end
        end
        ptr_after = rr_index(grant_idx, 1);
        grant_val = div_slot[grant_idx];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        val_d   = val_q;
        ack_d   = '0;
        err_d   = '0;
        en_d    = 1'b0;
        cfg_d   = 1'b0;
        din_d   = '0;
        cur_d   = CUR_DIV;
        case (state_q)
            ST_IDLE: begin
                en_d = RUN;
                if (grant_found) begin
                    idx_d = grant_idx;
                    val_d = grant_val;
                    ptr_d = ptr_after;
                    if (grant_val == '0) begin
                        err_d[grant_idx] = 1'b1;
`ifdef DIV_SKIP_SAME_EN
                    end else if (grant_val == CUR_DIV) begin
                        state_d          = ST_RESUME;
                        ack_d[grant_idx] = 1'b1;
`endif
                    end else begin
                        state_d = ST_DISABLE;
                        en_d    = 1'b0;
                    end
                end
            end
            ST_DISABLE: begin
                state_d = ST_LOAD;
                cfg_d   = 1'b1;
                din_d   = val_q;
            end
            ST_LOAD: begin
                cur_d = val_q;
                if (SETTLE_CYCLES == 0) begin
                    state_d      = ST_RESUME;
                    ack_d[idx_q] = 1'b1;
                    en_d         = RUN;
                end else begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d      = ST_RESUME;
                    ack_d[idx_q] = 1'b1;
                    en_d         = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESUME: begin
                state_d = ST_IDLE;
                en_d    = RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            idx_q      <= '0;
            val_q      <= '0;
            ACK        <= '0;
            ACK_ERR    <= '0;
            DIV_ENABLE <= 1'b0;
            DIV_CONFIG <= 1'b0;
            DIV_DIN_n  <= '0;
            CUR_DIV    <= WIDTH'(1);
            BUSY       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            val_q      <= val_d;
            ACK        <= ack_d;
            ACK_ERR    <= err_d;
            DIV_ENABLE <= en_d;
            DIV_CONFIG <= cfg_d;
            DIV_DIN_n  <= din_d;
            CUR_DIV    <= cur_d;
            BUSY       <= busy_d;
        end
    end

endmodule

// File: tb/tb_div_config_arbiter.sv
// Directed bench for div_config_arbiter with default parameters (4 requesters, 32-bit, settle 2).
module tb_div_config_arbiter;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic         RUN;
    logic [3:0]   REQ;
    logic [127:0] REQ_DIV;
    logic [3:0]   ACK, ACK_ERR;
    logic         DIV_ENABLE, DIV_CONFIG, BUSY;
    logic [31:0]  DIV_DIN_n, CUR_DIV;

    int total = 0;
    int bad   = 0;

    div_config_arbiter #(.NUM_REQ(4), .WIDTH(32), .SETTLE_CYCLES(2)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN), .REQ(REQ), .REQ_DIV(REQ_DIV),
        .ACK(ACK), .ACK_ERR(ACK_ERR), .DIV_ENABLE(DIV_ENABLE), .DIV_CONFIG(DIV_CONFIG),
        .DIV_DIN_n(DIV_DIN_n), .CUR_DIV(CUR_DIV), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_div(input int i, input logic [31:0] v);
        REQ_DIV[i*32 +: 32] = v;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; RUN = 1'b0; REQ = '0; REQ_DIV = '0;
        #12;
        total++; if (CUR_DIV !== 32'd1) begin bad++; $display("FAIL reset_cur got=%0d exp=1", CUR_DIV); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        total++; if (DIV_ENABLE !== 1'b0 || DIV_CONFIG !== 1'b0) begin bad++; $display("FAIL reset_en_cfg got=%b%b exp=00", DIV_ENABLE, DIV_CONFIG); end
        total++; if (ACK !== 4'd0 || ACK_ERR !== 4'd0 || DIV_DIN_n !== 32'd0) begin bad++; $display("FAIL reset_ack_din ack=%b err=%b din=%0d exp=0", ACK, ACK_ERR, DIV_DIN_n); end
        @(negedge CLK); RESET_N = 1'b1;
        step(); step();
        total++; if (DIV_ENABLE !== 1'b0) begin bad++; $display("FAIL run_low_en got=%b exp=0", DIV_ENABLE); end
        RUN = 1'b1;
        #1;
        total++; if (DIV_ENABLE !== 1'b0) begin bad++; $display("FAIL run_latency got=%b exp=0", DIV_ENABLE); end
        step();
        total++; if (DIV_ENABLE !== 1'b1) begin bad++; $display("FAIL run_follow got=%b exp=1", DIV_ENABLE); end
        total++; if (CUR_DIV !== 32'd1 || BUSY !== 1'b0) begin bad++; $display("FAIL idle_state cur=%0d busy=%b exp=1,0", CUR_DIV, BUSY); end
    endtask

    task automatic test_single();
        logic [5:0] exp_en, exp_cfg, exp_ack, exp_busy;
        exp_en   = 6'b110000;
        exp_cfg  = 6'b000010;
        exp_ack  = 6'b010000;
        exp_busy = 6'b011111;
        set_div(0, 32'd3);
        REQ = 4'b0001;
        for (int s = 1; s <= 6; s++) begin
            step();
            total++; if (DIV_ENABLE !== exp_en[s-1]) begin bad++; $display("FAIL single_en step=%0d got=%b exp=%b", s, DIV_ENABLE, exp_en[s-1]); end
            total++; if (DIV_CONFIG !== exp_cfg[s-1]) begin bad++; $display("FAIL single_cfg step=%0d got=%b exp=%b", s, DIV_CONFIG, exp_cfg[s-1]); end
            total++; if (ACK !== {3'b000, exp_ack[s-1]}) begin bad++; $display("FAIL single_ack step=%0d got=%b exp=%b", s, ACK, exp_ack[s-1]); end
            total++; if (BUSY !== exp_busy[s-1]) begin bad++; $display("FAIL single_busy step=%0d got=%b exp=%b", s, BUSY, exp_busy[s-1]); end
            if (s == 2) begin
                total++; if (DIV_DIN_n !== 32'd3) begin bad++; $display("FAIL single_din got=%0d exp=3", DIV_DIN_n); end
                total++; if (CUR_DIV !== 32'd1) begin bad++; $display("FAIL single_cur_early got=%0d exp=1", CUR_DIV); end
            end
            if (s == 3) begin
                total++; if (CUR_DIV !== 32'd3) begin bad++; $display("FAIL single_cur got=%0d exp=3", CUR_DIV); end
            end
            if (s == 5) REQ = 4'b0000;
        end
    endtask

    task automatic test_round_robin();
        int          order [6];
        int          vals  [4];
        int          n;
        logic [3:0]  dropped;
        logic [31:0] last_din;
        order = '{0, 1, 3, 0, 1, 3};
        vals  = '{5, 6, 9, 7};
        @(negedge CLK); RESET_N = 1'b0;
        @(negedge CLK); RESET_N = 1'b1;
        RUN = 1'b1;
        for (int i = 0; i < 4; i++) set_div(i, vals[i]);
        REQ = 4'b1011;
        n = 0; dropped = '0; last_din = '0;
        for (int s = 0; s < 80 && n < 6; s++) begin
            step();
            REQ = REQ | dropped;
            dropped = '0;
            if (DIV_CONFIG) last_din = DIV_DIN_n;
            if (ACK !== 4'd0) begin
                total++; if (ACK !== (4'b0001 << order[n])) begin bad++; $display("FAIL rr_order n=%0d got=%b exp=%0d", n, ACK, order[n]); end
                total++; if (last_din !== vals[order[n]]) begin bad++; $display("FAIL rr_din n=%0d got=%0d exp=%0d", n, last_din, vals[order[n]]); end
                n++;
                REQ = REQ & ~ACK;
                dropped = ACK;
            end
        end
        total++; if (n != 6) begin bad++; $display("FAIL rr_timeout acks=%0d exp=6", n); end
        REQ = '0;
        step(); step();
        total++; if (CUR_DIV !== 32'd7) begin bad++; $display("FAIL rr_cur got=%0d exp=7", CUR_DIV); end
    endtask

    task automatic test_zero();
        set_div(2, 32'd0);
        REQ = 4'b0100;
        step();
        total++; if (ACK_ERR !== 4'b0100) begin bad++; $display("FAIL zero_err got=%b exp=0100", ACK_ERR); end
        total++; if (ACK !== 4'd0 || DIV_CONFIG !== 1'b0) begin bad++; $display("FAIL zero_no_load ack=%b cfg=%b exp=0", ACK, DIV_CONFIG); end
        total++; if (DIV_ENABLE !== 1'b1 || BUSY !== 1'b0) begin bad++; $display("FAIL zero_en_busy en=%b busy=%b exp=1,0", DIV_ENABLE, BUSY); end
        REQ = 4'b0000;
        step();
        total++; if (ACK_ERR !== 4'd0) begin bad++; $display("FAIL zero_err_pulse got=%b exp=0000", ACK_ERR); end
        total++; if (CUR_DIV !== 32'd7 || DIV_ENABLE !== 1'b1) begin bad++; $display("FAIL zero_cur cur=%0d en=%b exp=7,1", CUR_DIV, DIV_ENABLE); end
    endtask

    task automatic test_run_low();
        logic en_seen;
        int   ack_at;
        RUN = 1'b0;
        step();
        set_div(3, 32'd6);
        REQ = 4'b1000;
        en_seen = 1'b0; ack_at = 0;
        for (int s = 1; s <= 7; s++) begin
            step();
            if (DIV_ENABLE) en_seen = 1'b1;
            if (ACK[3] && ack_at == 0) begin ack_at = s; REQ = '0; end
            if (s == 2) begin
                total++; if (DIV_CONFIG !== 1'b1 || DIV_DIN_n !== 32'd6) begin bad++; $display("FAIL runlow_load cfg=%b din=%0d exp=1,6", DIV_CONFIG, DIV_DIN_n); end
            end
        end
        total++; if (en_seen !== 1'b0) begin bad++; $display("FAIL runlow_en got=%b exp=0", en_seen); end
        total++; if (ack_at != 5) begin bad++; $display("FAIL runlow_ack step=%0d exp=5", ack_at); end
        total++; if (CUR_DIV !== 32'd6) begin bad++; $display("FAIL runlow_cur got=%0d exp=6", CUR_DIV); end
    endtask

    task automatic test_reset_mid();
        int ack_at;
        logic ack_seen;
        RUN = 1'b1;
        step();
        set_div(0, 32'd9);
        REQ = 4'b0001;
        step(); step(); step();
        total++; if (BUSY !== 1'b1 || CUR_DIV !== 32'd9) begin bad++; $display("FAIL mid_settle busy=%b cur=%0d exp=1,9", BUSY, CUR_DIV); end
        #2;
        RESET_N = 1'b0;
        REQ = '0;
        #1;
        total++; if (BUSY !== 1'b0 || DIV_ENABLE !== 1'b0 || DIV_CONFIG !== 1'b0) begin bad++; $display("FAIL mid_reset_out busy=%b en=%b cfg=%b exp=0", BUSY, DIV_ENABLE, DIV_CONFIG); end
        total++; if (CUR_DIV !== 32'd1 || ACK !== 4'd0) begin bad++; $display("FAIL mid_reset_cur cur=%0d ack=%b exp=1,0", CUR_DIV, ACK); end
        step(); step();
        @(negedge CLK); RESET_N = 1'b1;
        ack_seen = 1'b0;
        for (int s = 0; s < 6; s++) begin
            step();
            if (ACK !== 4'd0) ack_seen = 1'b1;
        end
        total++; if (ack_seen !== 1'b0) begin bad++; $display("FAIL mid_no_ack got=%b exp=0", ack_seen); end
        set_div(1, 32'd4);
        REQ = 4'b0010;
        ack_at = 0;
        for (int s = 1; s <= 8; s++) begin
            step();
            if (ACK !== 4'd0 && ack_at == 0) begin
                ack_at = s;
                total++; if (ACK !== 4'b0010) begin bad++; $display("FAIL mid_after_ack got=%b exp=0010", ACK); end
                REQ = '0;
            end
        end
        total++; if (ack_at != 5) begin bad++; $display("FAIL mid_after_lat step=%0d exp=5", ack_at); end
        total++; if (CUR_DIV !== 32'd4) begin bad++; $display("FAIL mid_after_cur got=%0d exp=4", CUR_DIV); end
    endtask

    task automatic test_same();
        int   ack_at, cfg_n, exp_ack2, exp_cfg2;
        logic en_drop, exp_drop2;
`ifdef DIV_SKIP_SAME_EN
        exp_ack2 = 1; exp_cfg2 = 0; exp_drop2 = 1'b0;
`else
        exp_ack2 = 5; exp_cfg2 = 1; exp_drop2 = 1'b1;
`endif
        set_div(1, 32'd3);
        for (int p = 0; p < 2; p++) begin
            REQ = 4'b0010;
            ack_at = 0; cfg_n = 0; en_drop = 1'b0;
            for (int s = 1; s <= 8; s++) begin
                step();
                if (!DIV_ENABLE) en_drop = 1'b1;
                if (DIV_CONFIG) cfg_n++;
                if (ACK[1] && ack_at == 0) begin ack_at = s; REQ = '0; end
            end
            total++; if (ack_at != ((p == 0) ? 5 : exp_ack2)) begin bad++; $display("FAIL same_lat pass=%0d got=%0d exp=%0d", p, ack_at, (p == 0) ? 5 : exp_ack2); end
            total++; if (cfg_n != ((p == 0) ? 1 : exp_cfg2)) begin bad++; $display("FAIL same_cfg pass=%0d got=%0d exp=%0d", p, cfg_n, (p == 0) ? 1 : exp_cfg2); end
            total++; if (en_drop !== ((p == 0) ? 1'b1 : exp_drop2)) begin bad++; $display("FAIL same_en_drop pass=%0d got=%b", p, en_drop); end
            total++; if (CUR_DIV !== 32'd3) begin bad++; $display("FAIL same_cur pass=%0d got=%0d exp=3", p, CUR_DIV); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero();
        test_run_low();
        test_reset_mid();
        test_same();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
